// File: rtl/ddr4_interleave_cmdgen.sv
// ddr4_interleave_cmdgen
//   Walks every bank of every bank group and drives one ACT phase, an optional
//   RD/WR phase and a single-bank PRE phase onto the DDR4 command/address pins.
//   Spacing inside a phase is TRRD_S when the bank group changes and TRRD_L
//   when it stays the same; TRCD, TC2P and TRP separate the phases.
//
// Ports
//   ck_t, reset_n      clock (rising edge), synchronous active-low reset
//   start              begin a sequence; only sampled while idle
//   mode               0: bank group cycles fastest, 1: bank cycles fastest
//   op                 00/11 none, 01 RD, 10 WR
//   rank, row, col     target rank, ACT row and CAS column (latched at start)
//   cs_n, act_n, A,
//   bg, ba             registered command/address pins
//   busy               high from the cycle after start until done
//   done               one-cycle pulse at the end of the sequence
module ddr4_interleave_cmdgen #(
    parameter int unsigned RANKS     = 1,
    parameter int unsigned BGWIDTH   = 2,
    parameter int unsigned BAWIDTH   = 2,
    parameter int unsigned ADDRWIDTH = 17,
    parameter int unsigned COLWIDTH  = 10,
    parameter int unsigned TRRD_S    = 4,
    parameter int unsigned TRRD_L    = 6,
    parameter int unsigned TRCD      = 16,
    parameter int unsigned TC2P      = 12,
    parameter int unsigned TRP       = 16,
    localparam int unsigned RankW    = (RANKS > 1) ? $clog2(RANKS) : 1
) (
    input  logic                 ck_t,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [1:0]           op,
    input  logic [RankW-1:0]     rank,
    input  logic [ADDRWIDTH-1:0] row,
    input  logic [COLWIDTH-1:0]  col,
    output logic [RANKS-1:0]     cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned IdxW = BGWIDTH + BAWIDTH;
    localparam int unsigned CntW = 16;

    localparam logic [IdxW-1:0] IdxLast = '1;

    // Counter reload values: a reload of N-1 places the next event N cycles later.
    localparam logic [CntW-1:0] GapS    = CntW'(TRRD_S - 1);
    localparam logic [CntW-1:0] GapL    = CntW'(TRRD_L - 1);
    localparam logic [CntW-1:0] RcdWait = CntW'(TRCD - 1);
    localparam logic [CntW-1:0] C2pWait = CntW'(TC2P - 1);
    localparam logic [CntW-1:0] RpWait  = CntW'(TRP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAct,
        StRcdWait,
        StCas,
        StC2pWait,
        StPre,
        StRpWait,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        CmdAct,
        CmdCas,
        CmdPre
    } cmd_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [CntW-1:0]        cnt_q, cnt_d;

    logic                   mode_q, mode_d;
    logic [1:0]             op_q, op_d;
    logic [RankW-1:0]       rank_q, rank_d;
    logic [ADDRWIDTH-1:0]   row_q, row_d;
    logic [COLWIDTH-1:0]    col_q, col_d;

    logic [RANKS-1:0]       cs_n_q, cs_n_d;
    logic                   act_n_q, act_n_d;
    logic [ADDRWIDTH-1:0]   a_q, a_d;
    logic [BGWIDTH-1:0]     bg_q, bg_d;
    logic [BAWIDTH-1:0]     ba_q, ba_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Bank index to (bg, ba) mapping for both walk orders.
    function automatic logic [BGWIDTH-1:0] idx_bg(input logic [IdxW-1:0] idx, input logic m);
        if (m) begin
            idx_bg = BGWIDTH'(idx >> BAWIDTH);
        end else begin
            idx_bg = BGWIDTH'(idx);
        end
    endfunction

    function automatic logic [BAWIDTH-1:0] idx_ba(input logic [IdxW-1:0] idx, input logic m);
        if (m) begin
            idx_ba = BAWIDTH'(idx);
        end else begin
            idx_ba = BAWIDTH'(idx >> BGWIDTH);
        end
    endfunction

    // The first ACT is issued on the accepting edge, before the latches hold
    // the request, so it uses the live inputs.
    logic                   eff_mode;
    logic [RankW-1:0]       eff_rank;
    logic [ADDRWIDTH-1:0]   eff_row;
    logic                   op_none;
    logic [IdxW-1:0]        idx_nxt;
    logic [BGWIDTH-1:0]     cur_bg;
    logic [BGWIDTH-1:0]     nxt_bg;
    logic [BAWIDTH-1:0]     cur_ba;

    always_comb begin
        eff_mode = (state_q == StIdle) ? mode : mode_q;
        eff_rank = (state_q == StIdle) ? rank : rank_q;
        eff_row  = (state_q == StIdle) ? row  : row_q;
        op_none  = (op_q == 2'b00) || (op_q == 2'b11);
        idx_nxt  = idx_q + IdxW'(1);
        cur_bg   = idx_bg(idx_q, eff_mode);
        nxt_bg   = idx_bg(idx_nxt, eff_mode);
        cur_ba   = idx_ba(idx_q, eff_mode);
    end

    logic fire;
    cmd_e fire_cmd;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        op_d     = op_q;
        rank_d   = rank_q;
        row_d    = row_q;
        col_d    = col_q;
        cs_n_d   = '1;
        act_n_d  = 1'b1;
        a_d      = a_q;
        bg_d     = bg_q;
        ba_d     = ba_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        fire     = 1'b0;
        fire_cmd = CmdAct;

        case (state_q)
            StIdle: begin
                if (start) begin
                    fire     = 1'b1;
                    fire_cmd = CmdAct;
                    busy_d   = 1'b1;
                    mode_d   = mode;
                    op_d     = op;
                    rank_d   = rank;
                    row_d    = row;
                    col_d    = col;
                end
            end
            StAct: begin
                if (cnt_q == '0) begin
                    fire     = 1'b1;
                    fire_cmd = CmdAct;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StRcdWait: begin
                if (cnt_q == '0) begin
                    fire     = 1'b1;
                    fire_cmd = op_none ? CmdPre : CmdCas;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StCas: begin
                if (cnt_q == '0) begin
                    fire     = 1'b1;
                    fire_cmd = CmdCas;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StC2pWait, StPre: begin
                if (cnt_q == '0) begin
                    fire     = 1'b1;
                    fire_cmd = CmdPre;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StRpWait: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                // start is deliberately not looked at here.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (fire) begin
            cs_n_d = ~(RANKS'(1) << eff_rank);
            bg_d   = cur_bg;
            ba_d   = cur_ba;
            if (idx_q == IdxLast) begin
                idx_d = '0;
            end else begin
                idx_d = idx_nxt;
                cnt_d = (nxt_bg == cur_bg) ? GapL : GapS;
            end
            case (fire_cmd)
                CmdAct: begin
                    act_n_d = 1'b0;
                    a_d     = eff_row;
                    if (idx_q == IdxLast) begin
                        state_d = StRcdWait;
                        cnt_d   = RcdWait;
                    end else begin
                        state_d = StAct;
                    end
                end
                CmdCas: begin
                    a_d                 = '0;
                    a_d[COLWIDTH-1:0]   = col_q;
                    a_d[16:14]          = (op_q == 2'b01) ? 3'b101 : 3'b100;
                    a_d[10]             = 1'b0; // no auto-precharge
                    if (idx_q == IdxLast) begin
                        state_d = StC2pWait;
                        cnt_d   = C2pWait;
                    end else begin
                        state_d = StCas;
                    end
                end
                default: begin
                    a_d        = '0;
                    a_d[16:14] = 3'b010; // A10=0 selects single-bank precharge
                    if (idx_q == IdxLast) begin
                        state_d = StRpWait;
                        cnt_d   = RpWait;
                    end else begin
                        state_d = StPre;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ck_t) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            op_q    <= 2'b00;
            rank_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            cs_n_q  <= '1;
            act_n_q <= 1'b1;
            a_q     <= '0;
            bg_q    <= '0;
            ba_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            op_q    <= op_d;
            rank_q  <= rank_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cs_n_q  <= cs_n_d;
            act_n_q <= act_n_d;
            a_q     <= a_d;
            bg_q    <= bg_d;
            ba_q    <= ba_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cs_n  = cs_n_q;
    assign act_n = act_n_q;
    assign A     = a_q;
    assign bg    = bg_q;
    assign ba    = ba_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
